pool_bin: RTL and testbench

Streaming 2x2/stride-2 max-pool plus sign binarization, directly downstream of `conv`. It consumes `conv`'s raster-order result stream (`dout`/`ovalid`/`done`), pools each frame (24x24→12x12 for layer 0, 8x8→4x4 for layer 1) and emits pooled values with a binarized bit for the next binary layer. There is no backpressure: the block must accept one input every cycle.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/pool_line_buf.sv | 24 ++
 rtl/pool_bin.sv | 125 ++++++++++++
 tb/tb_pool_bin.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and sizes for the binary CNN datapath.
// Reused by conv, pool_bin and downstream binary layers.
package bnn_pkg;

  localparam int DW     = 32;
  localparam int W0     = 24;
  localparam int W1     = 8;
  localparam int THRESH = 0;

  typedef logic signed [DW-1:0] conv_data_t;

  typedef enum logic {
    IDLE,
    RUN
  } pool_st_e;

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: single-port line buffer holding one row of
// horizontal 2:1 maxima; registered write, combinational read.
module pool_line_buf #(
  parameter int DEPTH = 12,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // contents are don't-care until written on an even row
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pool_bin.sv
// pool_bin: streaming 2x2/stride-2 max-pool with sign binarization
// on conv's raster-order result stream; no backpressure.
module pool_bin
  import bnn_pkg::*;
#(
  parameter int DW     = bnn_pkg::DW,
  parameter int W0     = bnn_pkg::W0,
  parameter int W1     = bnn_pkg::W1,
  parameter int THRESH = bnn_pkg::THRESH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 state,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_done,
  output logic signed [DW-1:0] out_data,
  output logic                 out_bit,
  output logic                 out_valid,
  output logic                 out_done,
  output logic                 busy,
  output logic                 err
);

  localparam int AW = $clog2(W0/2);

  typedef logic signed [DW-1:0] data_t;

  pool_st_e    st, st_nx;
  logic [4:0]  col, row;
  logic [4:0]  wm1;
  logic        wsel, wcur;
  logic        first, last_col;
  logic        frame_end, clr;
  logic        lb_we, emit;
  logic [AW-1:0] lb_addr;
  logic [DW-1:0] lb_rd;
  data_t       hold, pmax, res;

  // frame size is taken from state only at (0,0)
  assign first     = (row == '0) && (col == '0);
  assign wcur      = first ? state : wsel;
  assign wm1       = wcur ? 5'(W1-1) : 5'(W0-1);
  assign last_col  = (col == wm1);
  assign frame_end = in_valid && last_col && (row == wm1);
  assign clr       = frame_end || (in_valid && in_done);

  assign pmax    = (in_data > hold) ? in_data : hold;
  assign lb_addr = AW'(col >> 1);
  assign lb_we   = in_valid && !row[0] && col[0];
  assign emit    = in_valid && row[0] && col[0];
  assign res     = (data_t'(lb_rd) > pmax) ? data_t'(lb_rd) : pmax;

  pool_line_buf #(
    .DEPTH (W0/2),
    .DW    (DW),
    .AW    (AW)
  ) u_lbuf (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (pmax),
    .rdata (lb_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= IDLE;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    busy  = 1'b0;
    unique case (st)
      IDLE: begin
        if (in_valid && !clr) st_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (clr) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col  <= '0;
      row  <= '0;
      wsel <= 1'b0;
      hold <= '0;
    end else if (in_valid) begin
      if (first) wsel <= state;
      if (!col[0]) hold <= in_data;
      if (clr) begin
        col <= '0;
        row <= '0;
      end else if (last_col) begin
        col <= '0;
        row <= row + 5'd1;
      end else begin
        col <= col + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data  <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= emit;
      out_done  <= frame_end;
      if (emit) begin
        out_data <= res;
        out_bit  <= (res >= data_t'(THRESH));
      end
      if (in_valid && in_done && !frame_end) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pool_bin.sv
// tb_pool_bin: scoreboard bench for pool_bin; expected pooled values
// come from a stored copy of each driven frame.
module tb_pool_bin;

  logic               clk;
  logic               rstn;
  logic               state;
  logic signed [31:0] in_data;
  logic               in_valid;
  logic               in_done;
  logic signed [31:0] out_data;
  logic               out_bit;
  logic               out_valid;
  logic               out_done;
  logic               busy;
  logic               err;

  pool_bin dut (
    .clk       (clk),
    .rstn      (rstn),
    .state     (state),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_done   (in_done),
    .out_data  (out_data),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_done  (out_done),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    int     d;
    bit     b;
    bit     dn;
    longint stamp;
  } exp_t;

  exp_t   q[$];
  int     n_cmp;
  int     n_bad;
  longint cyc;
  int     fr [24][24];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].stamp == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("valid", {31'd0, out_valid}, 1);
      chk("data", out_data, e.d);
      chk("bit", {31'd0, out_bit}, {31'd0, e.b});
      chk("done", {31'd0, out_done}, {31'd0, e.dn});
    end else if (out_valid || out_done) begin
      chk("spurious", {30'd0, out_valid, out_done}, 0);
    end
  end

  function automatic int val(int kind, int w, int r, int c);
    case (kind)
      0:       return r*w + c;
      1:       return -(r*w + c);
      default: return -5;
    endcase
  endfunction

  function automatic int max4(int r, int c);
    int m;
    m = fr[r][c];
    if (fr[r-1][c-1] > m) m = fr[r-1][c-1];
    if (fr[r-1][c]   > m) m = fr[r-1][c];
    if (fr[r][c-1]   > m) m = fr[r][c-1];
    return m;
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_done  = 1'b0;
    in_data  = $urandom;
    state    = 1'($urandom);
  endtask

  task automatic run_frame(input bit sel, input int kind,
                           input int gmax, input int stop,
                           input bit early);
    int w, n, last;
    w    = sel ? 8 : 24;
    n    = w*w;
    last = (stop < 0) ? n-1 : stop;
    for (int idx = 0; idx <= last; idx++) begin
      int r, c, v;
      r = idx / w;
      c = idx % w;
      v = val(kind, w, r, c);
      fr[r][c] = v;
      repeat ($urandom_range(0, gmax)) idle_cycle();
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = v;
      in_done  = (idx == last) && (stop < 0 || early);
      state    = (idx == 0) ? sel : 1'($urandom);
      if (idx == 2) chk("busy_run", {31'd0, busy}, 1);
      if (r[0] && c[0]) begin
        exp_t e;
        e.d     = max4(r, c);
        e.b     = (e.d >= 0);
        e.dn    = (stop < 0) && (idx == n-1);
        e.stamp = cyc + 1;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_done  = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_data"}, out_data, 0);
    chk({pfx, "_bit"}, {31'd0, out_bit}, 0);
    chk({pfx, "_valid"}, {31'd0, out_valid}, 0);
    chk({pfx, "_done"}, {31'd0, out_done}, 0);
    chk({pfx, "_busy"}, {31'd0, busy}, 0);
    chk({pfx, "_err"}, {31'd0, err}, 0);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rstn     = 1'b0;
    state    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_done  = 1'b0;
    #1;
    chk_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    run_frame(1'b0, 0, 0, -1, 1'b0);
    drain();
    chk("ramp_busy", {31'd0, busy}, 0);
    chk("ramp_err", {31'd0, err}, 0);

    run_frame(1'b1, 1, 0, -1, 1'b0);
    drain();

    run_frame(1'b0, 2, 0, -1, 1'b0);
    drain();

    run_frame(1'b0, 0, 3, -1, 1'b0);
    drain();

    run_frame(1'b0, 0, 0, 99, 1'b1);
    drain();
    chk("early_err", {31'd0, err}, 1);
    chk("early_busy", {31'd0, busy}, 0);

    run_frame(1'b0, 0, 2, -1, 1'b0);
    drain();
    chk("err_sticky", {31'd0, err}, 1);

    run_frame(1'b0, 0, 0, 299, 1'b0);
    rstn = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    run_frame(1'b0, 0, 0, -1, 1'b0);
    drain();
    chk("post_err", {31'd0, err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
